instr_fetch: RTL and testbench

- Instruction fetch unit: the producer side of the `nextIns`/`instructions` interface into the multi-cycle `control` FSM.
- Holds the program counter and fetches 9-bit instruction words from a synchronous instruction ROM. It latches each word into an instruction register and presents opcode and operand to `control` and the datapath.
- Applies taken branches (BLQZ) and signals `done` when the program counter leaves the program.

---
 rtl/definitions.sv | 25 ++
 rtl/pc_unit.sv | 47 ++++
 rtl/instr_fetch.sv | 114 +++++++++++
 tb/tb_instr_fetch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/definitions.sv
// rtl/definitions.sv - shared fetch state, instruction field widths and opcodes
package definitions;

    localparam int INS_W     = 9;
    localparam int OPCODE_W  = 3;
    localparam int OPERAND_W = INS_W - OPCODE_W;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LATCH,
        HOLD,
        DONE
    } fetch_state_t;

    localparam logic [OPCODE_W-1:0] ADD  = 3'd0;
    localparam logic [OPCODE_W-1:0] XOR  = 3'd1;
    localparam logic [OPCODE_W-1:0] AND  = 3'd2;
    localparam logic [OPCODE_W-1:0] RSL  = 3'd3;
    localparam logic [OPCODE_W-1:0] MOV  = 3'd4;
    localparam logic [OPCODE_W-1:0] BLQZ = 3'd5;
    localparam logic [OPCODE_W-1:0] ST   = 3'd6;
    localparam logic [OPCODE_W-1:0] LD   = 3'd7;

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter, pending branch target and next-PC selection
module pc_unit #(
    parameter int          PC_W     = 8,
    parameter int unsigned PROG_LEN = 256
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            hold,
    input  logic            next_ins,
    input  logic            branch,
    input  logic [7:0]      branch_offset,
    output logic [PC_W-1:0] pc,
    output logic            halt
);

    logic [PC_W-1:0] pend;
    logic            pend_valid;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] next_pc;

    assign off_ext = PC_W'(signed'(branch_offset));
    assign target  = pc + off_ext;
    assign next_pc = branch ? target : (pend_valid ? pend : pc + PC_W'(1));
    // Compare in 32 bits so PROG_LEN == 2^PC_W never halts on wrap-free arithmetic.
    assign halt    = hold && next_ins && ({{(32-PC_W){1'b0}}, next_pc} >= PROG_LEN);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            pc         <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else if (hold) begin
            if (next_ins) begin
                pend_valid <= 1'b0;
                if (!halt) begin
                    pc <= next_pc;
                end
            end else if (branch) begin
                pend       <= target;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch FSM and instruction register; INS_COUNT_EN enables the issue counter
module instr_fetch
    import definitions::*;
#(
    parameter int          PC_W     = 8,
    parameter int unsigned PROG_LEN = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 nextIns,
    input  logic                 branch,
    input  logic [7:0]           branchOffset,
    output logic [PC_W-1:0]      imemAddr,
    input  logic [INS_W-1:0]     imemData,
    output logic [OPCODE_W-1:0]  instructions,
    output logic [OPERAND_W-1:0] operand,
    output logic                 insValid,
    output logic [PC_W-1:0]      pc,
    output logic                 done,
    output logic [15:0]          insCount
);

    fetch_state_t    state;
    logic [PC_W-1:0] fetch_pc;
    logic            halt;
    logic            clear;
    logic            hold;

    assign clear    = start && (state == IDLE || state == DONE);
    assign hold     = (state == HOLD);
    assign imemAddr = fetch_pc;

    pc_unit #(
        .PC_W     (PC_W),
        .PROG_LEN (PROG_LEN)
    ) u_pc_unit (
        .clock         (clock),
        .reset         (reset),
        .clear         (clear),
        .hold          (hold),
        .next_ins      (nextIns),
        .branch        (branch),
        .branch_offset (branchOffset),
        .pc            (fetch_pc),
        .halt          (halt)
    );

    // pc tracks the latched word, so it only moves together with the instruction register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            instructions <= '0;
            operand      <= '0;
            pc           <= '0;
            insValid     <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    state <= LATCH;
                end
                LATCH: begin
                    {instructions, operand} <= imemData;
                    pc                      <= fetch_pc;
                    insValid                <= 1'b1;
                    state                   <= HOLD;
                end
                HOLD: begin
                    if (nextIns) begin
                        insValid <= 1'b0;
                        if (halt) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        done  <= 1'b0;
                        state <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef INS_COUNT_EN
    logic [15:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (state == LATCH && count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end

    assign insCount = count;
`else
    assign insCount = 16'd0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized and directed check of instr_fetch against a transaction-level model
module tb_instr_fetch;

    localparam int PC_W     = 8;
    localparam int PROG_LEN = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            nextIns = 1'b0;
    logic            branch = 1'b0;
    logic [7:0]      branchOffset = 8'd0;
    logic [PC_W-1:0] imemAddr;
    logic [8:0]      imemData;
    logic [2:0]      instructions;
    logic [5:0]      operand;
    logic            insValid;
    logic [PC_W-1:0] pc;
    logic            done;
    logic [15:0]     insCount;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [8:0] rom [256];

    instr_fetch #(
        .PC_W     (PC_W),
        .PROG_LEN (PROG_LEN)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .nextIns      (nextIns),
        .branch       (branch),
        .branchOffset (branchOffset),
        .imemAddr     (imemAddr),
        .imemData     (imemData),
        .instructions (instructions),
        .operand      (operand),
        .insValid     (insValid),
        .pc           (pc),
        .done         (done),
        .insCount     (insCount)
    );

    always #5 clock = ~clock;

    always @(posedge clock) imemData <= rom[imemAddr];

    // Model: a fetch is either in flight (m_wait edges left), presented, or absent.
    bit         m_active = 0;
    bit         m_valid = 0;
    bit         m_done = 0;
    int         m_wait = 0;
    int         m_fetch = 0;
    int         m_pc = 0;
    int         m_pend = -1;
    int         m_count = 0;

    function automatic int sext8(input logic [7:0] v);
        return v[7] ? int'(v) - 256 : int'(v);
    endfunction

    always @(posedge clock) begin
        int nxt;
        if (reset) begin
            m_active = 0; m_valid = 0; m_done = 0; m_wait = 0;
            m_fetch = 0; m_pend = -1; m_count = 0;
        end else if (!m_active && start) begin
            m_active = 1; m_done = 0; m_fetch = 0; m_wait = 2; m_pend = -1; m_count = 0;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1;
                m_pc = m_fetch;
                if (m_count < 65535) m_count++;
            end
        end else if (m_valid) begin
            if (nextIns) begin
                if (branch) nxt = (m_pc + sext8(branchOffset)) & 255;
                else if (m_pend >= 0) nxt = m_pend;
                else nxt = (m_pc + 1) & 255;
                m_pend = -1;
                m_valid = 0;
                if (nxt >= PROG_LEN) begin
                    m_done = 1;
                    m_active = 0;
                end else begin
                    m_fetch = nxt;
                    m_wait = 2;
                end
            end else if (branch) begin
                m_pend = (m_pc + sext8(branchOffset)) & 255;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            logic [8:0] w;
            chk("m_valid", 32'(insValid), 32'(m_valid));
            chk("m_done", 32'(done), 32'(m_done));
            if (m_valid) begin
                w = rom[m_pc];
                chk("m_pc", 32'(pc), 32'(m_pc));
                chk("m_opcode", 32'(instructions), 32'(w[8:6]));
                chk("m_operand", 32'(operand), 32'(w[5:0]));
            end
            if (m_wait > 0) chk("m_imemAddr", 32'(imemAddr), 32'(m_fetch));
`ifdef INS_COUNT_EN
            chk("m_insCount", 32'(insCount), 32'(m_count));
`else
            chk("m_insCount", 32'(insCount), 32'd0);
`endif
        end
    end

    task automatic cyc(input logic s, input logic n, input logic b, input logic [7:0] off, input logic r);
        start = s; nextIns = n; branch = b; branchOffset = off; reset = r;
        @(posedge clock);
        #2;
        start = 0; nextIns = 0; branch = 0; reset = 0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 8'd0, 0);
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_valid"}, 32'(insValid), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_opcode"}, 32'(instructions), 32'd0);
        chk({tag, "_operand"}, 32'(operand), 32'd0);
        chk({tag, "_pc"}, 32'(pc), 32'd0);
        chk({tag, "_imemAddr"}, 32'(imemAddr), 32'd0);
        chk({tag, "_insCount"}, 32'(insCount), 32'd0);
    endtask

    initial begin
        logic [8:0] w;
        for (int i = 0; i < 256; i++) rom[i] = 9'($urandom);
        rom[0] = 9'b101_000011;

        cyc(0, 0, 0, 8'd0, 1);
        chk_en = 1'b1;
        cyc(0, 0, 0, 8'd0, 1);
        reset_chk("reset");

        cyc(1, 0, 0, 8'd0, 0);
        idle(1);
        chk("start_early_valid", 32'(insValid), 32'd0);
        idle(1);
        chk("start_valid", 32'(insValid), 32'd1);
        chk("start_opcode", 32'(instructions), 32'd5);
        chk("start_operand", 32'(operand), 32'd3);
        chk("start_pc", 32'(pc), 32'd0);

        for (int i = 1; i <= 5; i++) begin
            cyc(0, 1, 0, 8'd0, 0);
            chk("seq_gap0", 32'(insValid), 32'd0);
            idle(1);
            chk("seq_gap1", 32'(insValid), 32'd0);
            idle(1);
            w = rom[i];
            chk("seq_valid", 32'(insValid), 32'd1);
            chk("seq_pc", 32'(pc), 32'(i));
            chk("seq_word", 32'({instructions, operand}), 32'(w));
        end

        cyc(0, 1, 1, 8'hFE, 0);
        idle(2);
        chk("br_same_pc", 32'(pc), 32'd3);

        cyc(0, 0, 1, 8'd4, 0);
        idle(1);
        cyc(0, 1, 0, 8'd0, 0);
        idle(2);
        chk("br_defer_pc", 32'(pc), 32'd7);

        cyc(0, 1, 0, 8'd0, 0);
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_valid", 32'(insValid), 32'd0);
        cyc(0, 1, 0, 8'd0, 0);
        idle(2);
        chk("halt_hold_done", 32'(done), 32'd1);
        chk("halt_hold_valid", 32'(insValid), 32'd0);
        cyc(1, 0, 0, 8'd0, 0);
        chk("restart_done", 32'(done), 32'd0);
        idle(2);
        chk("restart_valid", 32'(insValid), 32'd1);
        chk("restart_pc", 32'(pc), 32'd0);

        cyc(0, 0, 1, 8'd5, 0);
        cyc(0, 0, 0, 8'd0, 1);
        reset_chk("rst_hold");
        cyc(1, 0, 0, 8'd0, 0);
        idle(2);
        cyc(0, 1, 0, 8'd0, 0);
        idle(2);
        chk("rst_pend_gone_pc", 32'(pc), 32'd1);

        cyc(0, 1, 0, 8'd0, 0);
        cyc(0, 0, 0, 8'd0, 1);
        reset_chk("rst_req");

        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 15) - 8),
                ($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
